// File: rtl/pwm_multi_analyzer_if.sv
// Signal bundle between pwm_multi_analyzer and the logic that drives and consumes it.
// Channel i of the flattened buses occupies bits [i*WIDTH +: WIDTH].
interface pwm_multi_analyzer_if #(
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned CNT_WIDTH = 12,
  parameter int unsigned PER_WIDTH = 16
);
  logic                          en;
  logic [CHANNELS-1:0]           pwm_in;
  logic [CHANNELS*CNT_WIDTH-1:0] width_out;
  logic [CHANNELS-1:0]           valid;
  logic [CHANNELS-1:0]           level_out;
  logic [CHANNELS-1:0]           timeout;
  logic [CHANNELS*PER_WIDTH-1:0] period_out;

  modport master (
    output en, pwm_in,
    input  width_out, valid, level_out, timeout, period_out
  );

  modport slave (
    input  en, pwm_in,
    output width_out, valid, level_out, timeout, period_out
  );
endinterface

// File: rtl/pwm_multi_analyzer.sv
// Multi-channel PWM high-time analyzer with hysteretic level and per-channel timeout.
// Optional rising-to-rising period measurement is built when PWM_PERIOD_MEAS_EN is defined.
module pwm_multi_analyzer #(
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned CNT_WIDTH = 12,
  parameter int unsigned MAX_COUNT = 2000,
  parameter int unsigned HIGH_TH   = 1900,
  parameter int unsigned LOW_TH    = 1100,
  parameter int unsigned PER_WIDTH = 16,
  parameter int unsigned TIMEOUT   = 25000
) (
  input logic                 clk,
  input logic                 rst,
  pwm_multi_analyzer_if.slave bus
);
  typedef enum logic [1:0] {StIdle, StHigh, StLow} state_e;

  localparam logic [CNT_WIDTH-1:0] MaxCnt = CNT_WIDTH'(MAX_COUNT);
  localparam logic [CNT_WIDTH-1:0] HighTh = CNT_WIDTH'(HIGH_TH);
  localparam logic [CNT_WIDTH-1:0] LowTh  = CNT_WIDTH'(LOW_TH);
  localparam logic [PER_WIDTH-1:0] ToCnt  = PER_WIDTH'(TIMEOUT);
  localparam logic [PER_WIDTH-1:0] ToLast = PER_WIDTH'(TIMEOUT - 1);

  logic [CHANNELS-1:0]  sync1_q, sync2_q, prev_q, rise, fall;
  state_e               state_q [CHANNELS];
  state_e               state_d [CHANNELS];
  logic [CNT_WIDTH-1:0] cnt_q   [CHANNELS];
  logic [CNT_WIDTH-1:0] cnt_d   [CHANNELS];
  logic [CNT_WIDTH-1:0] width_q [CHANNELS];
  logic [CNT_WIDTH-1:0] width_d [CHANNELS];
  logic [PER_WIDTH-1:0] tcnt_q  [CHANNELS];
  logic [PER_WIDTH-1:0] tcnt_d  [CHANNELS];
  logic [CHANNELS-1:0]  valid_q, valid_d, level_q, level_d, timeout_q, timeout_d;
`ifdef PWM_PERIOD_MEAS_EN
  logic [PER_WIDTH-1:0] period_q [CHANNELS];
  logic [PER_WIDTH-1:0] period_d [CHANNELS];
`endif

  assign rise = sync2_q & ~prev_q;
  assign fall = ~sync2_q & prev_q;

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      state_d[i]   = state_q[i];
      cnt_d[i]     = cnt_q[i];
      width_d[i]   = width_q[i];
      tcnt_d[i]    = tcnt_q[i];
      valid_d[i]   = 1'b0;
      level_d[i]   = level_q[i];
      timeout_d[i] = timeout_q[i];
`ifdef PWM_PERIOD_MEAS_EN
      period_d[i]  = period_q[i];
`endif
      if (!bus.en) begin
        state_d[i]   = StIdle;
        cnt_d[i]     = '0;
        tcnt_d[i]    = '0;
        timeout_d[i] = 1'b0;
      end else begin
        case (state_q[i])
          StIdle: begin
            if (rise[i]) begin
              cnt_d[i]   = CNT_WIDTH'(1);
              state_d[i] = StHigh;
            end
          end
          StLow: begin
            if (rise[i]) begin
              cnt_d[i]    = CNT_WIDTH'(1);
              state_d[i]  = StHigh;
`ifdef PWM_PERIOD_MEAS_EN
              period_d[i] = tcnt_q[i] + 1'b1;
`endif
            end
          end
          StHigh: begin
            if (fall[i]) begin
              width_d[i] = cnt_q[i];
              valid_d[i] = 1'b1;
              if (cnt_q[i] > HighTh) begin
                level_d[i] = 1'b1;
              end else if (cnt_q[i] < LowTh) begin
                level_d[i] = 1'b0;
              end
              state_d[i] = StLow;
            end else if (sync2_q[i] && (cnt_q[i] != MaxCnt)) begin
              cnt_d[i] = cnt_q[i] + 1'b1;
            end
          end
          default: state_d[i] = StIdle;
        endcase

        // A rise in the expiry cycle wins, so expiry is only evaluated without one.
        if (rise[i]) begin
          tcnt_d[i]    = '0;
          timeout_d[i] = 1'b0;
        end else if (tcnt_q[i] != ToCnt) begin
          tcnt_d[i] = tcnt_q[i] + 1'b1;
          if (tcnt_q[i] == ToLast) begin
            timeout_d[i] = 1'b1;
            level_d[i]   = 1'b0;
            state_d[i]   = StIdle;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      prev_q    <= '0;
      valid_q   <= '0;
      level_q   <= '0;
      timeout_q <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i]  <= StIdle;
        cnt_q[i]    <= '0;
        width_q[i]  <= '0;
        tcnt_q[i]   <= '0;
`ifdef PWM_PERIOD_MEAS_EN
        period_q[i] <= '0;
`endif
      end
    end else begin
      sync1_q   <= bus.pwm_in;
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
      valid_q   <= valid_d;
      level_q   <= level_d;
      timeout_q <= timeout_d;
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i]  <= state_d[i];
        cnt_q[i]    <= cnt_d[i];
        width_q[i]  <= width_d[i];
        tcnt_q[i]   <= tcnt_d[i];
`ifdef PWM_PERIOD_MEAS_EN
        period_q[i] <= period_d[i];
`endif
      end
    end
  end

  logic [CHANNELS*CNT_WIDTH-1:0] width_flat;
  logic [CHANNELS*PER_WIDTH-1:0] period_flat;

  always_comb begin
    width_flat  = '0;
    period_flat = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      width_flat[i*CNT_WIDTH +: CNT_WIDTH] = width_q[i];
`ifdef PWM_PERIOD_MEAS_EN
      period_flat[i*PER_WIDTH +: PER_WIDTH] = period_q[i];
`endif
    end
  end

  assign bus.width_out  = width_flat;
  assign bus.valid      = valid_q;
  assign bus.level_out  = level_q;
  assign bus.timeout    = timeout_q;
  assign bus.period_out = period_flat;
endmodule

// File: tb/tb_pwm_multi_analyzer.sv
// Bench for pwm_multi_analyzer: directed scenarios plus random pulse trains, checked every
// cycle against a timestamp-based reference model of pulse widths, periods and timeouts.
module tb_pwm_multi_analyzer;
  localparam int CH        = 4;
  localparam int CW        = 12;
  localparam int PW        = 16;
  localparam int MAX_COUNT = 2000;
  localparam int HIGH_TH   = 1900;
  localparam int LOW_TH    = 1100;
  localparam int TIMEOUT   = 25000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pwm_multi_analyzer_if #(.CHANNELS(CH), .CNT_WIDTH(CW), .PER_WIDTH(PW)) bus ();

  pwm_multi_analyzer #(
    .CHANNELS (CH),
    .CNT_WIDTH(CW),
    .MAX_COUNT(MAX_COUNT),
    .HIGH_TH  (HIGH_TH),
    .LOW_TH   (LOW_TH),
    .PER_WIDTH(PW),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Stimulus: per-channel queues of segments, positive = high for N samples, negative = low.
  int            segs [CH][$];
  int            rem  [CH];
  logic [CH-1:0] pins;
  bit            rand_mode;

  // Reference model state, expressed as edge timestamps on the delayed pad view.
  int            cyc;
  logic [CH-1:0] h1, h2, h3;
  int            t_rise [CH];
  int            t_ref  [CH];
  int            width_m [CH];
  int            period_m [CH];
  bit            armed [CH];
  bit            in_pulse [CH];
  bit            tmo_m [CH];
  bit            lvl_m [CH];
  bit            vld_m [CH];
  logic [3*CH-1:0]    exp_flags;
  logic [CH*CW-1:0]   exp_w;
  logic [CH*PW-1:0]   exp_p;
  int            vtot [CH];
  int            base [CH];
  int            dsum;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push(input int c, input bit lvl, input int len);
    segs[c].push_back(lvl ? len : -len);
  endtask

  task automatic step(input int n);
    int s;
    repeat (n) begin
      @(negedge clk);
      for (int c = 0; c < CH; c++) begin
        if (rem[c] == 0) begin
          if (segs[c].size() > 0) begin
            s       = segs[c].pop_front();
            pins[c] = (s > 0);
            rem[c]  = (s > 0) ? s : -s;
          end else if (rand_mode) begin
            pins[c] = ~pins[c];
            rem[c]  = pins[c] ? int'($urandom_range(2600, 1)) : int'($urandom_range(3000, 1));
          end else begin
            pins[c] = 1'b0;
            rem[c]  = 1;
          end
        end
        rem[c]--;
      end
      bus.pwm_in = pins;
    end
  endtask

  // The DUT acts at edge m on the pad value sampled two edges earlier.
  task automatic model_step();
    logic cur, prv;
    int   w;
    cyc++;
    for (int c = 0; c < CH; c++) begin
      cur      = h2[c];
      prv      = h3[c];
      vld_m[c] = 1'b0;
      if (rst) begin
        armed[c] = 0; in_pulse[c] = 0; tmo_m[c] = 0; lvl_m[c] = 0;
        width_m[c] = 0; period_m[c] = 0; t_rise[c] = cyc; t_ref[c] = cyc;
      end else if (!bus.en) begin
        armed[c] = 0; in_pulse[c] = 0; tmo_m[c] = 0; t_ref[c] = cyc;
      end else if (cur && !prv) begin
        if (armed[c] && !in_pulse[c]) period_m[c] = cyc - t_rise[c];
        t_rise[c] = cyc; t_ref[c] = cyc;
        armed[c] = 1; in_pulse[c] = 1; tmo_m[c] = 0;
      end else begin
        if (!cur && prv && in_pulse[c]) begin
          w = cyc - t_rise[c];
          if (w > MAX_COUNT) w = MAX_COUNT;
          width_m[c] = w;
          vld_m[c]   = 1'b1;
          if (w > HIGH_TH) lvl_m[c] = 1'b1;
          else if (w < LOW_TH) lvl_m[c] = 1'b0;
          in_pulse[c] = 0;
        end
        if (!tmo_m[c] && (cyc - t_ref[c] == TIMEOUT)) begin
          tmo_m[c] = 1; lvl_m[c] = 0; armed[c] = 0; in_pulse[c] = 0;
        end
      end
    end
    if (rst) begin
      h1 = '0; h2 = '0; h3 = '0;
    end else begin
      h3 = h2; h2 = h1; h1 = bus.pwm_in;
    end
    exp_p = '0;
    for (int c = 0; c < CH; c++) begin
      exp_flags[c]        = tmo_m[c];
      exp_flags[CH + c]   = lvl_m[c];
      exp_flags[2*CH + c] = vld_m[c];
      exp_w[c*CW +: CW]   = CW'(width_m[c]);
`ifdef PWM_PERIOD_MEAS_EN
      exp_p[c*PW +: PW]   = PW'(period_m[c]);
`endif
    end
  endtask

  initial begin
    cyc = 0;
    for (int c = 0; c < CH; c++) vtot[c] = 0;
    forever begin
      @(posedge clk);
      model_step();
      #1;
      check_val("flags", 64'({bus.valid, bus.level_out, bus.timeout}), 64'(exp_flags));
      check_val("width", 64'(bus.width_out), 64'(exp_w));
      check_val("period", 64'(bus.period_out), 64'(exp_p));
      for (int c = 0; c < CH; c++) vtot[c] += int'(bus.valid[c]);
    end
  end

  task automatic snap();
    for (int c = 0; c < CH; c++) base[c] = vtot[c];
  endtask

  initial begin
    rst = 1'b1; bus.en = 1'b0; pins = '0; bus.pwm_in = '0; rand_mode = 0;
    for (int c = 0; c < CH; c++) rem[c] = 0;
    step(3);
    rst = 1'b0; bus.en = 1'b1;

    // Single 1500-cycle pulse on channel 0.
    snap();
    push(0, 0, 50); push(0, 1, 1500); push(0, 0, 300);
    step(1900);
    check_val("single_width", 64'(bus.width_out[0 +: CW]), 64'(1500));
    check_val("single_level", 64'(bus.level_out[0]), 64'(0));
    check_val("single_valid_cnt", 64'(vtot[0] - base[0]), 64'(1));
    dsum = (vtot[1] - base[1]) + (vtot[2] - base[2]) + (vtot[3] - base[3]);
    check_val("others_silent", 64'(dsum), 64'(0));

    // Hysteresis: 1950 sets, 1500 holds, 1050 clears.
    push(0, 1, 1950); push(0, 0, 500); step(2450);
    check_val("hyst_1950_width", 64'(bus.width_out[0 +: CW]), 64'(1950));
    check_val("hyst_1950_level", 64'(bus.level_out[0]), 64'(1));
    push(0, 1, 1500); push(0, 0, 500); step(2000);
    check_val("hyst_1500_level", 64'(bus.level_out[0]), 64'(1));
    push(0, 1, 1050); push(0, 0, 500); step(1550);
    check_val("hyst_1050_width", 64'(bus.width_out[0 +: CW]), 64'(1050));
    check_val("hyst_1050_level", 64'(bus.level_out[0]), 64'(0));

    // Saturation on ch1 with an overlapping pulse on ch2.
    snap();
    push(1, 1, 2500); push(1, 0, 300);
    push(2, 0, 200); push(2, 1, 1200); push(2, 0, 1400);
    step(2900);
    check_val("sat_width1", 64'(bus.width_out[1*CW +: CW]), 64'(2000));
    check_val("sat_level1", 64'(bus.level_out[1]), 64'(1));
    check_val("indep_width2", 64'(bus.width_out[2*CW +: CW]), 64'(1200));
    check_val("indep_level2", 64'(bus.level_out[2]), 64'(0));
    check_val("sat_valid_cnt1", 64'(vtot[1] - base[1]), 64'(1));
    check_val("indep_valid_cnt2", 64'(vtot[2] - base[2]), 64'(1));

    // en dropped mid-pulse: pulse discarded, width holds.
    snap();
    push(2, 1, 1000); push(2, 0, 200);
    step(500); bus.en = 1'b0; step(300); bus.en = 1'b1; step(600);
    check_val("en_no_valid", 64'(vtot[2] - base[2]), 64'(0));
    check_val("en_width_hold", 64'(bus.width_out[2*CW +: CW]), 64'(1200));

    // Asynchronous reset in the middle of pulses on every channel.
    for (int c = 0; c < CH; c++) push(c, 1, 400);
    step(200);
    rst = 1'b1;
    #1;
    check_val("rst_width", 64'(bus.width_out), 64'(0));
    check_val("rst_flags", 64'({bus.valid, bus.level_out, bus.timeout}), 64'(0));
    check_val("rst_period", 64'(bus.period_out), 64'(0));
    step(300);
    rst = 1'b0;
    snap();
    step(600);
    dsum = 0;
    for (int c = 0; c < CH; c++) dsum += vtot[c] - base[c];
    check_val("rst_no_valid", 64'(dsum), 64'(0));

    // Timeout on ch3 while ch0 produces rises 20000 cycles apart.
    push(3, 1, 1950); push(3, 0, 25100);
    push(0, 1, 1000); push(0, 0, 19000); push(0, 1, 1000); push(0, 0, 6100);
    step(2100);
    check_val("pre_to_level3", 64'(bus.level_out[3]), 64'(1));
    check_val("pre_to_timeout3", 64'(bus.timeout[3]), 64'(0));
    step(25000);
    check_val("to_timeout3", 64'(bus.timeout[3]), 64'(1));
    check_val("to_level3", 64'(bus.level_out[3]), 64'(0));
`ifdef PWM_PERIOD_MEAS_EN
    check_val("period0", 64'(bus.period_out[0 +: PW]), 64'(20000));
`else
    check_val("period0", 64'(bus.period_out[0 +: PW]), 64'(0));
`endif
    push(3, 1, 100); push(3, 0, 100);
    step(250);
    check_val("to_clear3", 64'(bus.timeout[3]), 64'(0));

    // Random pulse trains with occasional en drops and one reset.
    rand_mode = 1;
    for (int k = 0; k < 10; k++) begin
      step(int'($urandom_range(1500, 500)));
      if (k == 5) begin
        rst = 1'b1; step(3); rst = 1'b0;
      end else begin
        bus.en = 1'b0; step(int'($urandom_range(40, 1))); bus.en = 1'b1;
      end
    end
    rand_mode = 0;
    step(3000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/pwm_multi_analyzer.md
# pwm_multi_analyzer

Multi-channel, parametrised successor to the single-channel PWM analyzer. It measures the high time of up to `CHANNELS` independent RC-style PWM inputs in clock cycles, with saturation at `MAX_COUNT`. Each width is classified into a digital level with hysteresis, and a channel whose signal stops is reported by a per-channel timeout. It sits between the pad synchronisers and the display/decode logic of the top-level `tt_um_` wrapper.

## Interface
Parameters:
- `CHANNELS`, 4: number of independent PWM inputs (1..8).
- `CNT_WIDTH`, 12: width of each pulse-width counter and result.
- `MAX_COUNT`, 2000: saturation value for the width; must be < 2^`CNT_WIDTH`.
- `HIGH_TH`, 1900: width strictly above this sets the level to 1.
- `LOW_TH`, 1100: width strictly below this clears the level to 0; must be < `HIGH_TH`.
- `PER_WIDTH`, 16: width of the period / timeout counter.
- `TIMEOUT`, 25000: cycles without a rising edge before a timeout; must be < 2^`PER_WIDTH`.

Ports:
- `clk` in 1: single clock (1 MHz nominal).
- `rst` in 1: asynchronous, active-high reset.
- `en` in 1: global enable.
- `pwm_in` in `CHANNELS`: raw asynchronous PWM inputs.
- `width_out` out `CHANNELS*CNT_WIDTH`: latched width per channel; channel i occupies bits [i*CNT_WIDTH +: CNT_WIDTH].
- `valid` out `CHANNELS`: one-cycle strobe per channel when its `width_out` updates.
- `level_out` out `CHANNELS`: hysteretic classification.
- `timeout` out `CHANNELS`: channel has seen no rising edge for `TIMEOUT` cycles.
- `period_out` out `CHANNELS*PER_WIDTH`: rising-to-rising period; present only with the macro (see Configuration).

## Operation
- Per channel:
  - 2-flop synchroniser, then a registered previous value for edge detection.
  - Rise = synced 1 and previous 0. Fall = synced 0 and previous 1.
- Per-channel FSM states: IDLE, HIGH, LOW.
  - IDLE: wait for rise. A channel already high when `en` rises is ignored until its next rise.
  - IDLE/LOW on rise: width counter := 1, go HIGH.
  - HIGH: width counter += 1 each cycle while synced high, saturating at `MAX_COUNT`.
  - HIGH on fall: `width_out` := counter, `valid` = 1 for one cycle, apply classification, go LOW.
  - HIGH on rise: not possible.
- Classification on each fall:
  - width > `HIGH_TH` → `level_out` := 1.
  - width < `LOW_TH` → `level_out` := 0.
  - Otherwise `level_out` holds.
- Timeout counter per channel:
  - Cleared to 0 on every rise; increments every cycle otherwise, saturating at `TIMEOUT`.
  - On reaching `TIMEOUT`: `timeout` := 1, `level_out` := 0, FSM → IDLE. `width_out` holds.
  - `timeout` clears on the next rise.
  - A rise in the same cycle the count would reach `TIMEOUT` wins: no timeout is raised.
- `en` = 0:
  - All FSMs are forced to IDLE; width and timeout counters are cleared; `timeout` is cleared.
  - `width_out`, `level_out` and `period_out` hold.
  - No `valid` is generated. A pulse in progress is discarded.
  - Synchronisers keep running.
- Channels are fully independent. Simultaneous events on different channels are all handled in the same cycle.

## Timing
- Reset values: `width_out` = 0, `valid` = 0, `level_out` = 0, `timeout` = 0, `period_out` = 0, all FSMs in IDLE, synchronisers 0.
- Rise and fall are detected 3 `clk` edges after the pad transition. Both edges share the same latency, so a pin high for N sampled cycles yields width N (N ≤ `MAX_COUNT`).
- `valid` and the new `width_out`/`level_out` appear in the cycle after the fall-detect cycle, i.e. 4 cycles after the pad falls.
- `timeout` asserts `TIMEOUT` cycles after the last rise-detect cycle. This also holds after reset or `en` rising, counting from that point.
- `rst` asynchronously clears all state, including mid-pulse; counting resumes only after the next rise.

## Configuration
- Macro: `PWM_PERIOD_MEAS_EN`.
- Defined:
  - On each rise while in LOW, `period_out` for that channel := cycles since the previous rise (timeout counter value + 1).
  - The first rise after IDLE does not update `period_out`.
  - The update coincides with the rise-detect cycle + 1; no separate strobe.
- Undefined: `period_out` is tied to 0 and the period latch registers are not built. The timeout counter remains.

## Test plan
- Reset: assert `rst` mid-pulse on all channels → every output 0 immediately; after release, no `valid` until a full new pulse.
- Single pulse: `en` = 1, channel 0 high 1500 cycles → `width_out[0]` = 1500, `valid[0]` one cycle, `level_out[0]` = 0 (hysteresis); other channels silent.
- Hysteresis: pulses of 1950, 1500 and 1050 cycles → `level_out` goes 1, stays 1, then 0.
- Saturation and independence:
  - 2500-cycle pulse on ch1 → width 2000, level 1.
  - Concurrent 1200-cycle pulse on ch2 → width 1200, both `valid` correct and independent.
- Timeout: one 1950-cycle pulse, then idle 25000 cycles → `timeout` = 1, `level_out` = 0; next rise clears `timeout`.
- `en` and period:
  - `en` low mid-pulse → no `valid`, `width_out` holds.
  - With `PWM_PERIOD_MEAS_EN`, rises 20000 cycles apart → `period_out` = 20000.
  - Without the macro, `period_out` stays 0.
